// File: rtl/prism_input_cond.sv
// prism_input_cond: per-pin input conditioner ahead of the PRISM FSM.
// Each bit is optionally inverted, then either passed through with one
// register of latency or debounced against a programmable threshold.
// Clean levels, one-cycle edge pulses, sticky W1C edge flags and a
// maskable interrupt are produced from the conditioned levels.
module prism_input_cond #(
  parameter int WIDTH   = 7,
  parameter int DB_BITS = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  pin_in,
  input  logic              cfg_wr,
  input  logic [1:0]        cfg_addr,
  input  logic [31:0]       cfg_wdata,
  output logic [31:0]       cfg_rdata,
  output logic [WIDTH-1:0]  cond_out,
  output logic [WIDTH-1:0]  rise_pulse,
  output logic [WIDTH-1:0]  fall_pulse,
  output logic              irq
);

  logic [DB_BITS-1:0] thresh_r;
  logic [WIDTH-1:0]   en_r;
  logic [WIDTH-1:0]   inv_r;
  logic [WIDTH-1:0]   rflag_r;
  logic [WIDTH-1:0]   fflag_r;
  logic [WIDTH-1:0]   rmask_r;
  logic [WIDTH-1:0]   fmask_r;
  logic [DB_BITS-1:0] cnt_r [WIDTH];
  logic [DB_BITS-1:0] cnt_s [WIDTH];
  logic [WIDTH-1:0]   cond_r;
  logic [WIDTH-1:0]   cond_s;
  logic [WIDTH-1:0]   prev_r;
  logic [WIDTH-1:0]   rise_r;
  logic [WIDTH-1:0]   fall_r;
  logic [WIDTH-1:0]   samp_s;
  logic [WIDTH-1:0]   rise_s;
  logic [WIDTH-1:0]   fall_s;
  logic [WIDTH-1:0]   rclr_s;
  logic [WIDTH-1:0]   fclr_s;
  logic               unused_wdata_s;

  // Only some write-data bits land in registers; the rest are ignored.
  assign unused_wdata_s = ^cfg_wdata;

  assign samp_s = pin_in ^ inv_r;
  assign rise_s = cond_r & ~prev_r;
  assign fall_s = ~cond_r & prev_r;

  // Per-bit bypass / debounce next-state: a pending difference commits once
  // the counter has reached the threshold, so lowering T mid-count commits
  // on the next pending cycle and the counter never wraps.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      cond_s[i] = cond_r[i];
      cnt_s[i]  = {DB_BITS{1'b0}};
      if (!en_r[i]) begin
        cond_s[i] = samp_s[i];
      end else if (samp_s[i] == cond_r[i]) begin
        cnt_s[i] = {DB_BITS{1'b0}};
      end else if (cnt_r[i] >= thresh_r) begin
        cond_s[i] = samp_s[i];
      end else begin
        cnt_s[i] = cnt_r[i] + {{(DB_BITS-1){1'b0}}, 1'b1};
      end
    end
  end

  // Write-1-to-clear masks for the sticky flags.
  always_comb begin
    rclr_s = {WIDTH{1'b0}};
    fclr_s = {WIDTH{1'b0}};
    if (cfg_wr && (cfg_addr == 2'd2)) begin
      rclr_s = cfg_wdata[WIDTH-1:0];
      fclr_s = cfg_wdata[16 +: WIDTH];
    end else begin
      rclr_s = {WIDTH{1'b0}};
      fclr_s = {WIDTH{1'b0}};
    end
  end

  // Configuration registers, debounce state, edge pulses and sticky flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      thresh_r <= {DB_BITS{1'b0}};
      en_r     <= {WIDTH{1'b0}};
      inv_r    <= {WIDTH{1'b0}};
      rmask_r  <= {WIDTH{1'b0}};
      fmask_r  <= {WIDTH{1'b0}};
      rflag_r  <= {WIDTH{1'b0}};
      fflag_r  <= {WIDTH{1'b0}};
      cond_r   <= {WIDTH{1'b0}};
      prev_r   <= {WIDTH{1'b0}};
      rise_r   <= {WIDTH{1'b0}};
      fall_r   <= {WIDTH{1'b0}};
      for (int i = 0; i < WIDTH; i++) begin
        cnt_r[i] <= {DB_BITS{1'b0}};
      end
    end else begin
      if (cfg_wr) begin
        case (cfg_addr)
          2'd0: thresh_r <= cfg_wdata[DB_BITS-1:0];
          2'd1: begin
            en_r  <= cfg_wdata[WIDTH-1:0];
            inv_r <= cfg_wdata[16 +: WIDTH];
          end
          2'd3: begin
            rmask_r <= cfg_wdata[WIDTH-1:0];
            fmask_r <= cfg_wdata[16 +: WIDTH];
          end
          default: ;
        endcase
      end
      cond_r  <= cond_s;
      prev_r  <= cond_r;
      rise_r  <= rise_s;
      fall_r  <= fall_s;
      // Set wins over a same-cycle clear.
      rflag_r <= (rflag_r & ~rclr_s) | rise_s;
      fflag_r <= (fflag_r & ~fclr_s) | fall_s;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_r[i] <= cnt_s[i];
      end
    end
  end

  // Register read mux; unused bits read as zero.
  always_comb begin
    cfg_rdata = 32'd0;
    case (cfg_addr)
      2'd0: cfg_rdata[DB_BITS-1:0] = thresh_r;
      2'd1: begin
        cfg_rdata[WIDTH-1:0]  = en_r;
        cfg_rdata[16 +: WIDTH] = inv_r;
      end
      2'd2: begin
        cfg_rdata[WIDTH-1:0]  = rflag_r;
        cfg_rdata[16 +: WIDTH] = fflag_r;
      end
      2'd3: begin
        cfg_rdata[WIDTH-1:0]  = rmask_r;
        cfg_rdata[16 +: WIDTH] = fmask_r;
      end
      default: cfg_rdata = 32'd0;
    endcase
  end

  assign cond_out   = cond_r;
  assign rise_pulse = rise_r;
  assign fall_pulse = fall_r;
  assign irq        = |((rflag_r & rmask_r) | (fflag_r & fmask_r));

endmodule

// File: tb/tb_prism_input_cond.sv
// Randomised + directed bench for prism_input_cond against a cycle model
// that tracks, per bit, how long the sampled input has disagreed with the
// conditioned level.
module tb_prism_input_cond;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  pin_in = 7'd0;
  logic        cfg_wr = 1'b0;
  logic [1:0]  cfg_addr = 2'd0;
  logic [31:0] cfg_wdata = 32'd0;
  logic [31:0] cfg_rdata;
  logic [6:0]  cond_out, rise_pulse, fall_pulse;
  logic        irq;

  int n_checks = 0;
  int n_errors = 0;

  // model state
  logic [7:0] m_t;
  logic [6:0] m_en, m_inv, m_cond, m_last, m_rise, m_fall;
  logic [6:0] m_rflag, m_fflag, m_rmask, m_fmask;
  int         run [7];

  prism_input_cond dut (
    .clk(clk), .rst_n(rst_n), .pin_in(pin_in), .cfg_wr(cfg_wr),
    .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
    .cond_out(cond_out), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
    .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_rd(input logic [1:0] a);
    case (a)
      2'd0:    return {24'd0, m_t};
      2'd1:    return {9'd0, m_inv, 9'd0, m_en};
      2'd2:    return {9'd0, m_fflag, 9'd0, m_rflag};
      default: return {9'd0, m_fmask, 9'd0, m_rmask};
    endcase
  endfunction

  function automatic logic model_irq();
    return |((m_rflag & m_rmask) | (m_fflag & m_fmask));
  endfunction

  task automatic model_reset();
    m_t = 8'd0; m_en = 7'd0; m_inv = 7'd0; m_cond = 7'd0; m_last = 7'd0;
    m_rise = 7'd0; m_fall = 7'd0; m_rflag = 7'd0; m_fflag = 7'd0;
    m_rmask = 7'd0; m_fmask = 7'd0;
    for (int i = 0; i < 7; i++) run[i] = 0;
  endtask

  // One clock: predict from current inputs, clock, then compare outputs.
  task automatic tick();
    logic [6:0] s, nc, nr, nf, rclr, fclr;
    s  = pin_in ^ m_inv;
    nc = m_cond;
    for (int i = 0; i < 7; i++) begin
      if (!m_en[i]) begin
        nc[i] = s[i]; run[i] = 0;
      end else if (s[i] == m_cond[i]) begin
        run[i] = 0;
      end else if (run[i] + 1 > int'(m_t)) begin
        nc[i] = s[i]; run[i] = 0;   // disagreed for T+1 cycles in a row
      end else begin
        run[i] = run[i] + 1;
      end
    end
    nr = m_cond & ~m_last;          // level changed up at the previous clock
    nf = ~m_cond & m_last;
    rclr = 7'd0; fclr = 7'd0;
    if (cfg_wr && cfg_addr == 2'd2) begin
      rclr = cfg_wdata[6:0]; fclr = cfg_wdata[22:16];
    end
    @(posedge clk);
    #1;
    if (cfg_wr) begin
      case (cfg_addr)
        2'd0: m_t = cfg_wdata[7:0];
        2'd1: begin m_en = cfg_wdata[6:0]; m_inv = cfg_wdata[22:16]; end
        2'd3: begin m_rmask = cfg_wdata[6:0]; m_fmask = cfg_wdata[22:16]; end
        default: ;
      endcase
    end
    m_rflag = (m_rflag & ~rclr) | nr;
    m_fflag = (m_fflag & ~fclr) | nf;
    m_last = m_cond; m_cond = nc; m_rise = nr; m_fall = nf;
    check("cond", {25'd0, cond_out}, {25'd0, m_cond});
    check("rise", {25'd0, rise_pulse}, {25'd0, m_rise});
    check("fall", {25'd0, fall_pulse}, {25'd0, m_fall});
    check("irq", {31'd0, irq}, {31'd0, model_irq()});
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    cfg_wr = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_wr = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [1:0] a);
    cfg_addr = a;
    #1;
    check(tag, cfg_rdata, model_rd(a));
  endtask

  initial begin
    model_reset();
    #12 rst_n = 1'b1;
    check("rst_cond", {25'd0, cond_out}, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    for (int a = 0; a < 4; a++) rd_check("rst_rd", 2'(a));

    // bypass: 0x00 -> 0x05
    repeat (2) tick();
    pin_in = 7'h05;
    tick();
    check("byp_cond", {25'd0, cond_out}, 32'h5);
    check("byp_rise0", {25'd0, rise_pulse}, 32'h0);
    tick();
    check("byp_rise1", {25'd0, rise_pulse}, 32'h5);
    tick();
    check("byp_rise2", {25'd0, rise_pulse}, 32'h0);
    rd_check("byp_flags", 2'd2);
    check("byp_flags_abs", cfg_rdata, 32'h5);

    // debounce T=4 on bit0: short glitch rejected, 5-cycle hold accepted
    pin_in = 7'h00;
    repeat (3) tick();
    wr(2'd2, 32'h007f007f);
    wr(2'd0, 32'hffff_ff04);         // upper bits ignored
    rd_check("thresh_rd", 2'd0);
    wr(2'd1, 32'h0000_0001);
    pin_in = 7'h01;
    repeat (3) tick();
    pin_in = 7'h00;
    repeat (6) tick();
    check("glitch_cond", {31'd0, cond_out[0]}, 32'd0);
    pin_in = 7'h01;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check("db_commit", {31'd0, cond_out[0]}, (k == 5) ? 32'd1 : 32'd0);
    end
    repeat (3) tick();

    // invert bit3 in bypass, mask, W1C
    pin_in = 7'h00;
    repeat (8) tick();
    wr(2'd1, 32'h0008_0000);
    tick();
    check("inv_cond3", {31'd0, cond_out[3]}, 32'd1);
    tick();
    wr(2'd3, 32'h0000_0008);
    check("inv_irq", {31'd0, irq}, 32'd1);
    wr(2'd2, 32'h0000_0008);
    check("w1c_irq", {31'd0, irq}, 32'd0);

    // W1C coincident with a new rise on bit3: set wins
    pin_in = 7'h08;
    repeat (3) tick();
    pin_in = 7'h00;
    tick();
    wr(2'd2, 32'h0000_0008);
    rd_check("setwins_flags", 2'd2);
    check("setwins_bit", {31'd0, cfg_rdata[3]}, 32'd1);
    check("setwins_irq", {31'd0, irq}, 32'd1);

    // lower T mid-count: T=200, count to ~100, then T=10 commits next cycle
    wr(2'd1, 32'h0000_0002);
    wr(2'd0, 32'd200);
    pin_in = 7'h02;
    repeat (100) tick();
    wr(2'd0, 32'd10);
    check("lowT_hold", {31'd0, cond_out[1]}, 32'd0);
    tick();
    check("lowT_commit", {31'd0, cond_out[1]}, 32'd1);

    // reset in the middle of debouncing with flags set
    wr(2'd3, 32'h007f_007f);
    wr(2'd1, 32'h0000_007f);
    pin_in = 7'h7c;
    repeat (30) tick();
    #2 rst_n = 1'b0;
    #1;
    check("arst_cond", {25'd0, cond_out}, 32'd0);
    check("arst_rise", {25'd0, rise_pulse}, 32'd0);
    check("arst_fall", {25'd0, fall_pulse}, 32'd0);
    check("arst_irq", {31'd0, irq}, 32'd0);
    model_reset();
    pin_in = 7'h00;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    for (int a = 0; a < 4; a++) rd_check("post_rst_rd", 2'(a));
    repeat (3) tick();

    // randomised traffic with small thresholds
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 99) < 25) pin_in = 7'($urandom);
      if ($urandom_range(0, 99) < 6) begin
        logic [1:0]  a;
        logic [31:0] d;
        a = 2'($urandom_range(0, 3));
        d = $urandom;
        if (a == 2'd0) d[7:0] = 8'($urandom_range(0, 5));
        wr(a, d);
      end else begin
        tick();
      end
      rd_check("rand_rd", 2'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/prism_input_cond.md
Name: prism_input_cond

Overview:
- Per-pin input conditioner that sits directly upstream of the PRISM FSM controller. It drives the low seven bits of PRISM's in_data.
- Takes already-synchronised ui_in pins and applies, per bit: optional inversion, then a programmable debounce filter.
- Produces clean levels plus single-cycle rise/fall pulses for the FSM.
- Captures sticky edge flags and raises a maskable interrupt. Configured through the TinyQV peripheral register port.

Parameters:
- WIDTH, 7, number of conditioned input bits.
- DB_BITS, 8, width of the debounce threshold and of each per-bit counter.

Ports:
- clk  input  1  peripheral clock (64 MHz nominal).
- rst_n  input  1  reset, asynchronous, active-low.
- pin_in  input  WIDTH  synchronised pad inputs (ui_in[WIDTH-1:0]).
- cfg_wr  input  1  32-bit register write strobe, single cycle.
- cfg_addr  input  2  register select.
- cfg_wdata  input  32  write data.
- cfg_rdata  output  32  read data, combinational from cfg_addr.
- cond_out  output  WIDTH  debounced levels to PRISM in_data[WIDTH-1:0].
- rise_pulse  output  WIDTH  1-cycle pulse on each 0->1 transition of cond_out.
- fall_pulse  output  WIDTH  1-cycle pulse on each 1->0 transition of cond_out.
- irq  output  1  OR of (flags AND mask).

Behaviour:
- Registers:
  - addr 0 THRESH: [DB_BITS-1:0] debounce threshold T; other bits read 0.
  - addr 1 MODE: [WIDTH-1:0] debounce enable per bit; [16+WIDTH-1:16] invert per bit.
  - addr 2 FLAGS: [WIDTH-1:0] sticky rise flags; [16+WIDTH-1:16] sticky fall flags. Write-1-to-clear.
  - addr 3 MASK: same layout as FLAGS. Enables each flag into irq.
- Reset: T, MODE, FLAGS, MASK, all counters, cond_out, rise_pulse, fall_pulse and irq = 0.
- Sample: s[i] = pin_in[i] XOR invert[i].
- Bypass (debounce enable[i]=0):
  - cond_out[i] <= s[i] every cycle; 1-cycle latency.
  - cnt[i] held at 0.
- Debounce (enable[i]=1), per-bit state, evaluated every cycle:
  - STABLE (s[i]==cond_out[i]): cnt[i] <= 0.
  - PENDING (s[i]!=cond_out[i]) and cnt[i] >= T: cond_out[i] <= s[i], cnt[i] <= 0.
  - PENDING and cnt[i] < T: cnt[i] <= cnt[i]+1.
  - Result: a change held for T+1 consecutive cycles appears on cond_out T+1 cycles after it first appears on s.
  - A glitch shorter than T+1 cycles returns to STABLE, resets cnt and produces no change.
  - T=0 behaves identically to bypass.
  - The >= compare makes lowering T mid-count safe: the next PENDING cycle commits.
  - cnt never exceeds T, so it never wraps.
- Edge outputs:
  - rise_pulse[i] = cond_out[i] & ~cond_prev[i]; fall_pulse[i] = ~cond_out[i] & cond_prev[i].
  - cond_prev is a register of cond_out, so each pulse is high exactly one cycle, the cycle after cond_out changes.
- Sticky flags:
  - A flag sets on the cycle its pulse is high.
  - A FLAGS write clears every bit written as 1.
  - Set and clear in the same cycle: set wins.
- irq: combinational |(FLAGS & MASK), so it asserts the cycle a flag sets.
  - Writing a MASK bit on an already-set flag raises irq the next cycle.
- Invert change:
  - Treated as an input change on s and debounced normally.
  - Generates edge pulses and flags the same way a pin change does.
- Enable change:
  - Switching a bit from debounce to bypass takes effect immediately.
  - cnt[i] clears the same cycle.
- Reset asserted mid-debounce: counters and levels return to 0 immediately, asynchronously. No pulse is emitted on reset release unless s differs from 0 afterwards.
- cfg_wr with cfg_addr 0/1/3 updates the register on the next clock edge.
- Writes to unused bits are ignored; unused bits read 0.

Test Plan:
- Reset, MODE=0, pin_in toggles 0x00->0x05: cond_out=0x05 one cycle later; rise_pulse=0x05 for exactly one cycle the following cycle; FLAGS=0x00000005.
- T=4, debounce enable bit0, pin0 high for 3 cycles then low: cond_out[0] stays 0, no pulse. Pin0 high for 5 cycles: cond_out[0]=1 exactly 5 cycles after the change, one rise_pulse.
- Invert bit3 set with pin3=0, bypass: cond_out[3]=1 after 1 cycle, rise flag bit3 set. MASK=0x8: irq=1. Write FLAGS=0x8: irq=0 next cycle.
- FLAGS W1C write on the same cycle as a new rise_pulse on that bit: flag remains 1, irq stays high.
- T=200, bit1 debouncing with cnt at 100, write T=10: cond_out[1] commits on the next cycle.
- Assert rst_n low with cnt mid-count and flags set: all outputs 0 asynchronously, cfg_rdata=0 at every address after release.
